// File: rtl/can_tx_pkg.sv
// Shared types and constants for the CAN TX priority queue.
// Contents: default frame geometry, can_frame_t payload, tx_state_e FSM encoding.
// Optional feature macro used by the queue: CAN_TX_RETRY_LIMIT_EN.
package can_tx_pkg;

  localparam int unsigned CAN_ID_W       = 11;
  localparam int unsigned CAN_DATA_BYTES = 8;
  localparam int unsigned CAN_MAX_DLC    = 8;

  // Frame as seen by the default (standard-ID, 8-byte) configuration.
  typedef struct packed {
    logic [CAN_ID_W-1:0]         id;
    logic [3:0]                  dlc;
    logic [CAN_DATA_BYTES*8-1:0] data;
  } can_frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    TX     = 2'd2
  } tx_state_e;

endpackage

// File: rtl/can_tx_min_find.sv
// Combinational minimum-ID search over valid-masked slots.
// Ports: valid (slot occupancy), ids (slot identifiers),
//        found_c (any slot valid), idx_c (winning slot; lowest index on ties).
module can_tx_min_find #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 11,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [ID_W-1:0]  ids [DEPTH],
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [ID_W-1:0] best_id;

  // Strict less-than keeps the earlier (lower-index) slot on equal IDs.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    best_id = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (!found_c || (ids[i] < best_id))) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
        best_id = ids[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_prio_queue.sv
// CAN TX priority queue: buffers up to DEPTH frames and hands the lowest-ID
// frame to the bit engine through a start_tx / tx_done / tx_arb_lost handshake.
// Ports: host side tx_request/req_id/req_dlc/req_data, req_ready, overflow, count;
//        engine side start_tx, tx_id/tx_dlc/tx_data, tx_done, tx_arb_lost, tx_drop.
// Optional feature: CAN_TX_RETRY_LIMIT_EN adds per-slot arbitration-loss counters
// and drops a frame (tx_drop pulse) once it has lost MAX_RETRY times.
module can_tx_prio_queue
  import can_tx_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ID_W       = CAN_ID_W,
  parameter int unsigned DATA_BYTES = CAN_DATA_BYTES,
  parameter int unsigned MAX_RETRY  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_request,
  input  logic [ID_W-1:0]            req_id,
  input  logic [3:0]                 req_dlc,
  input  logic [7:0]                 req_data [DATA_BYTES],
  output logic                       req_ready,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       start_tx,
  output logic [ID_W-1:0]            tx_id,
  output logic [3:0]                 tx_dlc,
  output logic [7:0]                 tx_data [DATA_BYTES],
  input  logic                       tx_done,
  input  logic                       tx_arb_lost,
  output logic                       tx_drop
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  tx_state_e        state_q, state_d;
  logic [DEPTH-1:0] valid_q;
  logic [ID_W-1:0]  slot_id   [DEPTH];
  logic [3:0]       slot_dlc  [DEPTH];
  logic [7:0]       slot_data [DEPTH][DATA_BYTES];
  logic [IDX_W-1:0] sel_idx_q;

  logic             min_found;
  logic [IDX_W-1:0] min_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             ins_ok, sel_load, done_ok, arb_ok, drop_c, free_ok;
  logic [CNT_W-1:0] count_d;

  can_tx_min_find #(.DEPTH(DEPTH), .ID_W(ID_W)) u_min_find (
    .valid   (valid_q),
    .ids     (slot_id),
    .found_c (min_found),
    .idx_c   (min_idx)
  );

  // Lowest-index free slot, judged on occupancy before the edge.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Handshake qualifiers; tx_done takes precedence over tx_arb_lost.
  assign ins_ok   = tx_request && free_found;
  assign sel_load = (state_q == SELECT) && min_found;
  assign done_ok  = (state_q == TX) && tx_done;
  assign arb_ok   = (state_q == TX) && tx_arb_lost && !tx_done;
  assign free_ok  = done_ok || drop_c;
  assign count_d  = count + CNT_W'(ins_ok) - CNT_W'(free_ok);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|valid_q) state_d = SELECT;
      SELECT:  state_d = min_found ? TX : IDLE;
      TX:      if (tx_done || tx_arb_lost) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slot storage; the freed slot (selected) and inserted slot (free) never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_id[i]  <= '0;
        slot_dlc[i] <= '0;
        for (int b = 0; b < DATA_BYTES; b++) slot_data[i][b] <= '0;
      end
    end else begin
      if (free_ok) valid_q[sel_idx_q] <= 1'b0;
      if (ins_ok) begin
        valid_q[free_idx]  <= 1'b1;
        slot_id[free_idx]  <= req_id;
        slot_dlc[free_idx] <= req_dlc;
        for (int b = 0; b < DATA_BYTES; b++) slot_data[free_idx][b] <= req_data[b];
      end
    end
  end

  // Host flow control and transmitter-facing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      req_ready <= 1'b1;
      overflow  <= 1'b0;
      start_tx  <= 1'b0;
      sel_idx_q <= '0;
      tx_id     <= '0;
      tx_dlc    <= '0;
      for (int b = 0; b < DATA_BYTES; b++) tx_data[b] <= '0;
    end else begin
      count     <= count_d;
      req_ready <= (count_d != CNT_W'(DEPTH));
      overflow  <= tx_request && !free_found;
      if (sel_load) begin
        sel_idx_q <= min_idx;
        tx_id     <= slot_id[min_idx];
        tx_dlc    <= slot_dlc[min_idx];
        for (int b = 0; b < DATA_BYTES; b++) tx_data[b] <= slot_data[min_idx][b];
        start_tx  <= 1'b1;
      end else if (done_ok || arb_ok) begin
        start_tx  <= 1'b0;
      end
    end
  end

`ifdef CAN_TX_RETRY_LIMIT_EN
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY+1);

  logic [RETRY_W-1:0] retry_q [DEPTH];
  logic [RETRY_W-1:0] retry_inc;

  assign retry_inc = retry_q[sel_idx_q] + RETRY_W'(1);
  assign drop_c    = arb_ok && (retry_inc == RETRY_W'(MAX_RETRY));

  // Per-slot loss counters; a frame reaching the limit is freed instead of re-queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_drop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) retry_q[i] <= '0;
    end else begin
      tx_drop <= drop_c;
      if (ins_ok) retry_q[free_idx] <= '0;
      if (arb_ok && !drop_c) retry_q[sel_idx_q] <= retry_inc;
    end
  end
`else
  assign drop_c  = 1'b0;
  assign tx_drop = 1'b0;
`endif

endmodule

// File: tb/tb_can_tx_prio_queue.sv
// Self-checking bench for can_tx_prio_queue: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a slot-level model.
module tb_can_tx_prio_queue;
  import can_tx_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TB_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_request;
  logic [10:0] req_id;
  logic [3:0]  req_dlc;
  logic [7:0]  req_data [8];
  logic        req_ready, overflow, start_tx, tx_drop;
  logic [2:0]  count;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [7:0]  tx_data [8];
  logic        tx_done, tx_arb_lost;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  can_tx_prio_queue #(.DEPTH(DEPTH), .ID_W(11), .DATA_BYTES(8), .MAX_RETRY(TB_RETRY)) dut (
    .clk(clk), .rst(rst), .tx_request(tx_request), .req_id(req_id), .req_dlc(req_dlc),
    .req_data(req_data), .req_ready(req_ready), .overflow(overflow), .count(count),
    .start_tx(start_tx), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_drop(tx_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_valid [DEPTH];
  can_frame_t m_frame [DEPTH];
  int         m_retry [DEPTH];
  int         m_phase;       // 0 waiting for work, 1 arbitration cycle, 2 transmitting
  int         m_sel;
  bit         m_start, m_ovf, m_drop;
  can_frame_t m_tx;
  int         m_cnt;
  int         m_ins, m_best;
  bit         m_any;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_retry[i] = 0;
      end
      m_phase = 0; m_sel = 0; m_start = 1'b0; m_ovf = 1'b0; m_drop = 1'b0;
      m_tx = '0; m_cnt = 0;
    end else begin
      m_ins = -1;
      m_any = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!m_valid[i] && m_ins < 0) m_ins = i;
        if (m_valid[i]) m_any = 1'b1;
      end
      m_ovf  = tx_request && (m_ins < 0);
      m_drop = 1'b0;
      case (m_phase)
        0: if (m_any) m_phase = 1;
        1: begin
          m_best = -1;
          for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && (m_best < 0 || m_frame[i].id < m_frame[m_best].id)) m_best = i;
          m_sel = m_best; m_tx = m_frame[m_best]; m_start = 1'b1; m_phase = 2;
        end
        default: begin
          if (tx_done) begin
            m_valid[m_sel] = 1'b0; m_start = 1'b0; m_phase = 0;
          end else if (tx_arb_lost) begin
            m_start = 1'b0; m_phase = 0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            m_retry[m_sel]++;
            if (m_retry[m_sel] == TB_RETRY) begin
              m_valid[m_sel] = 1'b0; m_drop = 1'b1;
            end
`endif
          end
        end
      endcase
      if (tx_request && m_ins >= 0) begin
        m_valid[m_ins] = 1'b1;
        m_retry[m_ins] = 0;
        m_frame[m_ins].id  = req_id;
        m_frame[m_ins].dlc = req_dlc;
        for (int b = 0; b < 8; b++) m_frame[m_ins].data[b*8 +: 8] = req_data[b];
      end
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) if (m_valid[i]) m_cnt++;
    end
  end

  // Per-cycle comparison on the falling edge.
  logic [63:0] dut_data;
  always @(negedge clk) begin
    for (int b = 0; b < 8; b++) dut_data[b*8 +: 8] = tx_data[b];
    check("count",     64'(count),     64'(m_cnt));
    check("req_ready", 64'(req_ready), 64'(m_cnt < DEPTH));
    check("overflow",  64'(overflow),  64'(m_ovf));
    check("start_tx",  64'(start_tx),  64'(m_start));
    check("tx_drop",   64'(tx_drop),   64'(m_drop));
    check("tx_id",     64'(tx_id),     64'(m_tx.id));
    check("tx_dlc",    64'(tx_dlc),    64'(m_tx.dlc));
    check("tx_data",   dut_data,       m_tx.data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [10:0] id, input logic [3:0] dlc, input logic [7:0] base);
    tx_request = 1'b1;
    req_id     = id;
    req_dlc    = dlc;
    for (int b = 0; b < 8; b++) req_data[b] = base + 8'(b);
    tick();
    tx_request = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!start_tx && n < 20);
    if (!start_tx) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: start_tx timeout got 0 expected 1", name);
    end
  endtask

  task automatic pulse_done(input int gap);
    repeat (gap) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic pulse_arb();
    tx_arb_lost = 1'b1;
    tick();
    tx_arb_lost = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx_request = 1'b0; req_id = '0; req_dlc = '0;
    tx_done = 1'b0; tx_arb_lost = 1'b0;
    for (int b = 0; b < 8; b++) req_data[b] = '0;
    repeat (2) tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_start", 64'(start_tx), 64'd0);
    check("rst_tx_id", 64'(tx_id), 64'd0);
    rst = 1'b0;
    tick();

    // Priority order 100, 200, 300.
    req(11'd300, 4'd8, 8'hA0);
    req(11'd100, 4'd8, 8'hB0);
    req(11'd200, 4'd8, 8'hC0);
    check("ord_count3", 64'(count), 64'd3);
    wait_start("ord1");
    check("ord1_id", 64'(tx_id), 64'd100);
    check("ord1_d0", 64'(tx_data[0]), 64'hB0);
    check("ord1_d7", 64'(tx_data[7]), 64'hB7);
    pulse_done(5);
    wait_start("ord2");
    check("ord2_id", 64'(tx_id), 64'd200);
    check("ord2_d0", 64'(tx_data[0]), 64'hC0);
    pulse_done(5);
    wait_start("ord3");
    check("ord3_id", 64'(tx_id), 64'd300);
    check("ord3_d3", 64'(tx_data[3]), 64'hA3);
    pulse_done(5);
    check("ord_count0", 64'(count), 64'd0);
    repeat (3) tick();

    // Lower ID arriving during TX wins after arbitration loss.
    req(11'd200, 4'd2, 8'h20);
    wait_start("pre1");
    check("pre1_id", 64'(tx_id), 64'd200);
    req(11'd50, 4'd3, 8'h50);
    pulse_arb();
    check("pre_drop_start", 64'(start_tx), 64'd0);
    wait_start("pre2");
    check("pre2_id", 64'(tx_id), 64'd50);
    pulse_done(2);
    wait_start("pre3");
    check("pre3_id", 64'(tx_id), 64'd200);
    pulse_done(2);
    repeat (3) tick();

    // Fill to DEPTH, then overflow once.
    req(11'd10, 4'd1, 8'h01);
    req(11'd20, 4'd1, 8'h02);
    req(11'd30, 4'd1, 8'h03);
    req(11'd40, 4'd1, 8'h04);
    check("full_ready", 64'(req_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    req(11'd5, 4'd1, 8'h05);
    check("full_ovf", 64'(overflow), 64'd1);
    check("full_count5", 64'(count), 64'd4);
    tick();
    check("full_ovf_once", 64'(overflow), 64'd0);
    pulse_done(0);
    check("full_count_dn", 64'(count), 64'd3);
    wait_start("full_next");

    // Async reset mid-TX with three frames queued.
    rst = 1'b1;
    #1;
    check("arst_start", 64'(start_tx), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("arst_quiet", 64'(start_tx), 64'd0);
    end

    // Equal IDs: slot 0 goes first; DLC above 8 kept as-is.
    req(11'h123, 4'd12, 8'h11);
    req(11'h123, 4'd15, 8'h22);
    wait_start("tie1");
    check("tie1_d0", 64'(tx_data[0]), 64'h11);
    check("tie1_dlc", 64'(tx_dlc), 64'd12);
    pulse_done(1);
    wait_start("tie2");
    check("tie2_d0", 64'(tx_data[0]), 64'h22);
    check("tie2_dlc", 64'(tx_dlc), 64'd15);
    pulse_done(1);
    repeat (3) tick();

`ifdef CAN_TX_RETRY_LIMIT_EN
    // Three arbitration losses drop the frame.
    req(11'h10, 4'd4, 8'h40);
    for (int r = 1; r <= 3; r++) begin
      wait_start("retry");
      check("retry_id", 64'(tx_id), 64'h10);
      pulse_arb();
      check("retry_drop", 64'(tx_drop), 64'(r == 3));
    end
    check("retry_count", 64'(count), 64'd0);
    tick();
    check("retry_drop_once", 64'(tx_drop), 64'd0);
    repeat (3) tick();
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      tx_request = ($urandom_range(0, 99) < 35);
      req_id     = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      req_dlc    = 4'($urandom);
      for (int b = 0; b < 8; b++) req_data[b] = 8'($urandom);
      tx_done     = ($urandom_range(0, 99) < 15);
      tx_arb_lost = ($urandom_range(0, 99) < 12);
      tick();
    end
    tx_request = 1'b0; tx_done = 1'b0; tx_arb_lost = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/can_tx_prio_queue.md
Name: can_tx_prio_queue

Overview:
- Parametrised successor to the fixed-depth CAN TX priority arbiter.
- Buffers up to DEPTH pending frames. Presents the lowest-ID (highest-priority) frame to the bit-level transmitter via a start_tx/tx_done handshake.
- Adds full/overflow flow control, re-arbitration after bus arbitration loss (lower-ID arrivals preempt), and standard/extended ID width.
- Sits between the host request interface and the CAN TX bit engine.

Parameters:
- DEPTH, 4, number of frame slots (2..16).
- ID_W, 11, identifier width (11 standard, 29 extended).
- DATA_BYTES, 8, payload bytes per frame.
- MAX_RETRY, 8, arbitration-loss limit per frame; used only with CAN_TX_RETRY_LIMIT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_request  in  1  one-cycle strobe inserting a frame.
- req_id  in  ID_W  identifier of frame to insert.
- req_dlc  in  4  data length code.
- req_data  in  8 x DATA_BYTES  unpacked byte array payload.
- req_ready  out  1  high when at least one slot is free.
- overflow  out  1  one-cycle pulse: request dropped while full.
- count  out  $clog2(DEPTH+1)  occupied slots.
- start_tx  out  1  level; frame on tx_* is being transmitted.
- tx_id  out  ID_W  selected identifier.
- tx_dlc  out  4  selected DLC.
- tx_data  out  8 x DATA_BYTES  selected payload.
- tx_done  in  1  one-cycle strobe: frame sent and acknowledged.
- tx_arb_lost  in  1  one-cycle strobe: arbitration lost, frame stays queued.
- tx_drop  out  1  one-cycle pulse: frame discarded by retry limit. Constant 0 without the macro.

Behaviour:
- Reset, asynchronous:
  - All valid bits cleared; state IDLE.
  - start_tx=0, tx_id=0, tx_dlc=0, tx_data all 0.
  - count=0, req_ready=1, overflow=0, tx_drop=0.
- Insert: tx_request && req_ready at rising edge → frame written into the lowest-index free slot; count increments.
- Full: tx_request with count==DEPTH → frame discarded, overflow pulses the next cycle, storage unchanged.
- FSM IDLE:
  - If any valid slot → SELECT.
- FSM SELECT (one cycle):
  - Registers the slot with minimum ID among valid slots.
  - Ties resolved to the lowest slot index.
  - Loads tx_id/tx_dlc/tx_data; → TX.
- FSM TX:
  - start_tx=1; tx_* held stable; the selected slot is locked.
  - tx_done → slot freed, start_tx=0, → IDLE.
  - tx_arb_lost → slot kept, start_tx=0, → IDLE, and full re-arbitration follows. A lower ID inserted meanwhile wins.
  - tx_done and tx_arb_lost in the same cycle → tx_done wins.
- Latency: tx_request sampled at edge k into an empty queue → start_tx high after edge k+2. Held until tx_done or tx_arb_lost.
- tx_done/tx_arb_lost outside TX are ignored.
- Simultaneous insert and free in one cycle: both take effect; count unchanged. Insert may reuse only a slot that was free before that edge.
- tx_* keep their last values when start_tx=0.
- req_dlc is stored unchanged (9..15 not clamped).
- rst asserted mid-TX: start_tx drops immediately (async), all pending frames lost.

Optional Feature:
- Macro: CAN_TX_RETRY_LIMIT_EN.
- Defined:
  - Each slot carries a retry counter of width $clog2(MAX_RETRY+1), cleared on insert.
  - tx_arb_lost increments the counter.
  - When the increment reaches MAX_RETRY, the slot is freed instead of re-queued and tx_drop pulses for one cycle.
- Undefined:
  - No counters; retries are unlimited; tx_drop tied 0.

Decomposition:
- Package can_tx_pkg:
  - can_frame_t struct (id, dlc, data), parametrised via ID_W/DATA_BYTES package localparams with module overrides.
  - tx_state_e enum {IDLE, SELECT, TX}.
  - CAN_MAX_DLC=8 constant.
- Sub-module can_tx_min_find: combinational min-ID/lowest-index reduction over DEPTH valid-masked IDs. Outputs found flag and winning index.

Test Plan:
- Insert IDs 300, 100, 200 (data A0/B0/C0 increments), tx_done 5 cycles after each start_tx → transmit order 100, 200, 300 with matching payloads; count goes 3→0.
- During TX of ID 200, insert ID 50, then pulse tx_arb_lost → next start_tx carries ID 50; ID 200 follows after tx_done.
- DEPTH=4, five back-to-back inserts with no tx_done → req_ready low after the 4th, overflow pulses once on the 5th, count=4.
- Two frames with ID 0x123 in slots 0 and 1, different data → slot 0 data is transmitted first.
- Assert rst for one cycle while start_tx=1 with 3 frames queued → start_tx=0 immediately, count=0, req_ready=1, no later start_tx.
- CAN_TX_RETRY_LIMIT_EN, MAX_RETRY=3: ID 0x10 loses arbitration 3 times → tx_drop pulses on the 3rd, count decrements, queue empty.
